wm_cycle_ctrl: RTL
==================

// Module: wm_cycle_ctrl
// PURPOSE
//  Washing-machine programme sequencer. Steps FILL -> WASH -> DRAIN -> RINSE(xN) -> DRY -> DONE,
//  timed by an external 1 s strobe. Drives the phase/status LEDs and the fill/drain actuator enables.
//  Sits between the shared 1 ms/1 s timebase counters and the panel LED / valve outputs.
// PARAMETERS
//  T_FILL   2   base fill time in seconds; multiplied by (level+1). Must be >= 1.
//  T_WASH   600 wash time in seconds. Must be >= 1.
//  T_DRAIN  60  drain time in seconds. Must be >= 1.
//  T_RINSE  300 time per rinse pass in seconds. Must be >= 1.
//  T_DRY    420 spin/dry time in seconds. Must be >= 1.
//  CW       12  width of the seconds counter. Every T_* x 3 must fit in CW bits.
// PORTS
//  clk         in   1   system clock
//  rst         in   1   synchronous, active-high reset
//  tick_1s     in   1   one-clk strobe, once per second
//  start       in   1   one-clk pulse; honoured in IDLE or DONE only
//  pause       in   1   level; freezes timing while high
//  stop        in   1   one-clk pulse; aborts to IDLE
//  water_level in   2   0=low 1=mid 2=high 3=high
//  temp_sel    in   2   0=cold 1=hot 2=hot+cold 3=cold
//  repeat_cnt  in   2   extra rinse passes (0..3)
//  led_wash    out  1   wash phase LED
//  led_rinse   out  1   rinse phase LED
//  led_dry     out  1   dry phase LED
//  led_repeat  out  1   high while in RINSE with rinse passes still remaining
//  valve_hot   out  1   hot water valve
//  valve_cold  out  1   cold water valve
//  drain_on    out  1   drain pump
//  busy        out  1   state is not IDLE and not DONE
//  done        out  1   high in DONE
//  remain_sec  out  CW  seconds left in the current phase
// BEHAVIOUR
//  - States: IDLE, FILL, WASH, DRAIN, RINSE, DRY, DONE. All outputs are registered.
//  - Reset: state IDLE; all outputs 0; config latches 0; blink register 0.
//  - start in IDLE/DONE:
//      - latch water_level, temp_sel and repeat_cnt; ignore them at all other times.
//      - set rinse_left = repeat_cnt; enter FILL on the next clk.
//      - load remain_sec = T_FILL*(lvl+1), with lvl = min(water_level,2).
//  - start while busy: ignored.
//  - Phase entry: load remain_sec with that phase's duration in the same cycle as the state change.
//  - Countdown:
//      - on tick_1s with pause low: remain_sec decrements.
//      - a tick seen when remain_sec==1 ends the phase instead; next state and reload take effect next clk.
//      - each phase therefore spans exactly its duration in ticks.
//  - Transitions:
//      - FILL->WASH, WASH->DRAIN, DRAIN->RINSE, DRY->DONE.
//      - RINSE with rinse_left>0: stay in RINSE, reload T_RINSE, decrement rinse_left.
//      - RINSE with rinse_left==0: go to DRY.
//  - Actuators:
//      - FILL: valve_hot/valve_cold per latched temp_sel.
//      - DRAIN: drain_on=1.
//      - DRY: drain_on=1.
//      - all other states: actuators 0.
//      - while paused: valves and drain_on forced 0; state and remain_sec held.
//  - LEDs:
//      - active-phase LED blinks: a blink register toggles on each counted tick and clears on phase entry.
//      - active-phase LED is solid on while paused.
//      - completed-phase LEDs stay solid on; not-yet-reached LEDs stay off.
//      - FILL and WASH drive led_wash; DRAIN after WASH is still shown as wash complete.
//      - DONE: all three LEDs solid on.
//  - DONE: done=1, remain_sec=0; held until start (new cycle) or stop.
//  - Priority within one clk: rst > stop > pause > tick_1s. stop from any state -> IDLE next clk.
//  - stop or rst mid-phase: all outputs 0 next clk; config latches are not cleared by stop.
//  - A tick and a start in the same clk in IDLE: start is taken and the tick is not counted.
// TESTING (T_FILL=2 T_WASH=3 T_DRAIN=1 T_RINSE=2 T_DRY=2)
//  1. lvl0, repeat0, start, 10 ticks -> FILL 2 / WASH 3 / DRAIN 1 / RINSE 2 / DRY 2; done=1 after tick 10.
//  2. lvl2, temp_sel=2 -> FILL lasts 6 ticks with valve_hot=valve_cold=1; remain_sec 6,5,4,3,2,1.
//  3. repeat_cnt=2 -> 3 RINSE passes; done after tick 14; led_repeat high during the first two passes only.
//  4. pause high for 5 ticks mid-WASH -> remain_sec and state frozen, valves 0, led_wash solid; resumes correctly.
//  5. stop in RINSE -> IDLE next clk, all outputs 0; start in that same clk is ignored.
//  6. rst asserted mid-DRY -> IDLE, outputs 0; start while busy has no effect; start in DONE begins a new FILL.

Source files
------------

// File: rtl/wm_cycle_ctrl.sv
// wm_cycle_ctrl
//   Washing-machine programme sequencer. It steps through
//   FILL -> WASH -> DRAIN -> RINSE (1 + repeat passes) -> DRY -> DONE.
//   Each phase is timed by counting an external 1 s strobe.
//   The block drives the panel LEDs and the water valve and drain pump enables.
//
// Parameters
//   T_FILL   base fill time in seconds, scaled by (level + 1)
//   T_WASH   wash time in seconds
//   T_DRAIN  drain time in seconds
//   T_RINSE  time per rinse pass in seconds
//   T_DRY    spin/dry time in seconds
//   CW       width of the seconds counter (3 x every T_* must fit)
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   tick_1s         one-clk strobe per second
//   start, stop     one-clk pulses: start a programme / abort to idle
//   pause           level; freezes timing and shuts the actuators off
//   water_level     0 low, 1 mid, 2/3 high (latched at start)
//   temp_sel        0 cold, 1 hot, 2 hot+cold, 3 cold (latched at start)
//   repeat_cnt      extra rinse passes (latched at start)
//   led_wash/led_rinse/led_dry  phase LEDs: blinking = active,
//                   solid = complete (or active and paused)
//   led_repeat      in RINSE while more rinse passes remain
//   valve_hot/valve_cold/drain_on  actuator enables
//   busy, done      programme running / programme finished
//   remain_sec      seconds left in the current phase
module wm_cycle_ctrl #(
  parameter int T_FILL  = 2,
  parameter int T_WASH  = 600,
  parameter int T_DRAIN = 60,
  parameter int T_RINSE = 300,
  parameter int T_DRY   = 420,
  parameter int CW      = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick_1s,
  input  logic          start,
  input  logic          pause,
  input  logic          stop,
  input  logic [1:0]    water_level,
  input  logic [1:0]    temp_sel,
  input  logic [1:0]    repeat_cnt,
  output logic          led_wash,
  output logic          led_rinse,
  output logic          led_dry,
  output logic          led_repeat,
  output logic          valve_hot,
  output logic          valve_cold,
  output logic          drain_on,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] remain_sec
);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_WASH, S_DRAIN, S_RINSE, S_DRY, S_DONE
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] remain_n;
  logic [1:0]    rinse_left, rinse_n;
  logic [1:0]    temp_q, temp_n;
  logic          blink, blink_n;

  logic led_wash_n, led_rinse_n, led_dry_n, led_repeat_n;
  logic valve_hot_n, valve_cold_n, drain_on_n, busy_n, done_n;

  // Fill time grows with the requested water level; levels 2 and 3 are both "high".
  function automatic logic [CW-1:0] fill_time(input logic [1:0] wl);
    int lvl;
    lvl = (wl > 2'd2) ? 2 : int'(wl);
    return CW'(T_FILL * (lvl + 1));
  endfunction

  // Duration loaded on entry to a phase; DONE and IDLE show zero.
  function automatic logic [CW-1:0] phase_time(input state_t s);
    case (s)
      S_WASH:  return CW'(T_WASH);
      S_DRAIN: return CW'(T_DRAIN);
      S_RINSE: return CW'(T_RINSE);
      S_DRY:   return CW'(T_DRY);
      default: return '0;
    endcase
  endfunction

  // Next-state / countdown. stop beats everything except rst; a start in
  // IDLE/DONE swallows a coincident tick.
  always_comb begin
    state_n  = state;
    remain_n = remain_sec;
    rinse_n  = rinse_left;
    temp_n   = temp_q;
    blink_n  = blink;
    if (stop) begin
      state_n  = S_IDLE;
      remain_n = '0;
      blink_n  = 1'b0;
    end else if (state == S_IDLE || state == S_DONE) begin
      if (start) begin
        state_n  = S_FILL;
        remain_n = fill_time(water_level);
        rinse_n  = repeat_cnt;
        temp_n   = temp_sel;
        blink_n  = 1'b0;
      end
    end else if (!pause && tick_1s) begin
      if (remain_sec == CW'(1)) begin
        blink_n = 1'b0;
        case (state)
          S_FILL:  state_n = S_WASH;
          S_WASH:  state_n = S_DRAIN;
          S_DRAIN: state_n = S_RINSE;
          S_RINSE: begin
            if (rinse_left != 2'd0) rinse_n = rinse_left - 2'd1;
            else                    state_n = S_DRY;
          end
          S_DRY:   state_n = S_DONE;
          default: state_n = S_IDLE;
        endcase
        // A repeated rinse pass reloads T_RINSE because state_n stays RINSE.
        remain_n = phase_time(state_n);
      end else begin
        remain_n = remain_sec - CW'(1);
        blink_n  = ~blink;
      end
    end
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    logic act;
    act          = pause | ~blink_n;
    led_wash_n   = 1'b0;
    led_rinse_n  = 1'b0;
    led_dry_n    = 1'b0;
    led_repeat_n = 1'b0;
    valve_hot_n  = 1'b0;
    valve_cold_n = 1'b0;
    drain_on_n   = 1'b0;
    busy_n       = 1'b0;
    done_n       = 1'b0;
    case (state_n)
      S_FILL: begin
        led_wash_n   = act;
        valve_hot_n  = ~pause & ((temp_n == 2'd1) | (temp_n == 2'd2));
        valve_cold_n = ~pause & (temp_n != 2'd1);
        busy_n       = 1'b1;
      end
      S_WASH: begin
        led_wash_n = act;
        busy_n     = 1'b1;
      end
      S_DRAIN: begin
        led_wash_n = 1'b1;
        drain_on_n = ~pause;
        busy_n     = 1'b1;
      end
      S_RINSE: begin
        led_wash_n   = 1'b1;
        led_rinse_n  = act;
        led_repeat_n = (rinse_n != 2'd0);
        busy_n       = 1'b1;
      end
      S_DRY: begin
        led_wash_n  = 1'b1;
        led_rinse_n = 1'b1;
        led_dry_n   = act;
        drain_on_n  = ~pause;
        busy_n      = 1'b1;
      end
      S_DONE: begin
        led_wash_n  = 1'b1;
        led_rinse_n = 1'b1;
        led_dry_n   = 1'b1;
        done_n      = 1'b1;
      end
      default: ;
    endcase
  end

  // Register boundary: state, counters, config latches and all outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      remain_sec <= '0;
      rinse_left <= '0;
      temp_q     <= '0;
      blink      <= 1'b0;
      led_wash   <= 1'b0;
      led_rinse  <= 1'b0;
      led_dry    <= 1'b0;
      led_repeat <= 1'b0;
      valve_hot  <= 1'b0;
      valve_cold <= 1'b0;
      drain_on   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      remain_sec <= remain_n;
      rinse_left <= rinse_n;
      temp_q     <= temp_n;
      blink      <= blink_n;
      led_wash   <= led_wash_n;
      led_rinse  <= led_rinse_n;
      led_dry    <= led_dry_n;
      led_repeat <= led_repeat_n;
      valve_hot  <= valve_hot_n;
      valve_cold <= valve_cold_n;
      drain_on   <= drain_on_n;
      busy       <= busy_n;
      done       <= done_n;
    end
  end

endmodule
